// File: rtl/dev_input_pkg.sv
// Shared constants for the input peripheral: register addresses, STATUS layout.
package dev_input_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_CTRL   = 2'b10;

  localparam int STAT_VALID   = 0;
  localparam int STAT_OVERRUN = 1;
  localparam int STAT_CHG_LSB = 16;

  // STATUS word: {chg_cnt[15:0], 14'b0, overrun, valid}
  typedef struct packed {
    logic [15:0] chg_cnt;
    logic [13:0] rsvd;
    logic        overrun;
    logic        valid;
  } status_t;

  function automatic logic [31:0] pack_status(input logic [15:0] chg_cnt,
                                              input logic overrun,
                                              input logic valid);
    status_t s;
    s.chg_cnt = chg_cnt;
    s.rsvd    = '0;
    s.overrun = overrun;
    s.valid   = valid;
    return s;
  endfunction

endpackage

// File: rtl/dev_input_if.sv
// CPU-side bridge bus of the input peripheral (one 16-byte window).
interface dev_input_if;
  logic [1:0]  add;
  logic        read_en;
  logic        write_en;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        irq;

  modport master (output add, read_en, write_en, data_in, input data_out, irq);
  modport slave  (input add, read_en, write_en, data_in, output data_out, irq);
endinterface

// File: rtl/dev_input_debouncer.sv
// Two-flop synchroniser plus whole-word debouncer; accept is a one-cycle
// combinational pulse marking the edge at which stable takes the candidate.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ext_in,
  output logic [31:0] stable,
  output logic        accept
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [31:0]      sync1, sync2, cand;
  logic [CNT_W-1:0] count;

  // Candidate held long enough and differs from what the CPU currently sees.
  assign accept = (sync2 == cand) && (count == CNT_MAX) && (cand != stable);

  // Synchronise the asynchronous bus before any comparison.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ext_in;
      sync2 <= sync1;
    end
  end

  // Any bit change restarts the count; the count saturates once the word is settled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand   <= '0;
      count  <= '0;
      stable <= '0;
    end else if (sync2 != cand) begin
      cand  <= sync2;
      count <= '0;
    end else if (count != CNT_MAX) begin
      count <= count + CNT_W'(1);
    end else if (accept) begin
      stable <= cand;
    end
  end

endmodule

// File: rtl/dev_input.sv
// Memory-mapped input peripheral: debounced 32-bit input with valid/overrun
// status, change counter and level interrupt.
module dev_input
  import dev_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ext_in,
  dev_input_if.slave  bus
);

  logic [31:0] stable;
  logic        accept;
  logic        valid, overrun, irq_en;
  logic [15:0] chg_cnt;
  logic        data_rd, status_rd, ctrl_wr;
  logic        unused_data_in;

  input_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb (
    .clk    (clk),
    .reset  (reset),
    .ext_in (ext_in),
    .stable (stable),
    .accept (accept)
  );

  assign data_rd        = bus.read_en  && (bus.add == ADDR_DATA);
  assign status_rd      = bus.read_en  && (bus.add == ADDR_STATUS);
  assign ctrl_wr        = bus.write_en && (bus.add == ADDR_CTRL);
  assign unused_data_in = ^bus.data_in[31:1];

  // Valid/overrun/change-count bookkeeping; a new value beats a clearing read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
      chg_cnt <= '0;
    end else begin
      if (accept) begin
        valid   <= 1'b1;
        chg_cnt <= chg_cnt + 16'd1;
      end else if (data_rd) begin
        valid <= 1'b0;
      end
      if (accept && valid && !data_rd)
        overrun <= 1'b1;
      else if (status_rd)
        overrun <= 1'b0;
    end
  end

  // Interrupt enable, the only writable bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        irq_en <= 1'b0;
    else if (ctrl_wr) irq_en <= bus.data_in[0];
  end

  // Read mux is combinational from add; reserved word reads zero.
  always_comb begin
    bus.data_out = '0;
    case (bus.add)
      ADDR_DATA:   bus.data_out = stable;
      ADDR_STATUS: bus.data_out = pack_status(chg_cnt, overrun, valid);
      ADDR_CTRL:   bus.data_out = {31'b0, irq_en};
      default:     bus.data_out = '0;
    endcase
  end

  assign bus.irq = valid & irq_en;

endmodule
